dcache_controller: RTL and testbench
====================================

DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk_i  in  1  rising-edge clock; rst_i  in  1  asynchronous active-high reset.
REQ-002 The CPU-side ports SHALL be:
- cpu_addr_i  in  32  byte address.
- cpu_data_i  in  32  write word.
- cpu_MemRead_i  in  1  load request.
- cpu_MemWrite_i  in  1  store request.
- cpu_data_o  out  32  load word.
- cpu_stall_o  out  1  stall to all pipeline registers.
REQ-003 The memory-side ports SHALL be:
- mem_data_i  in  256  refill line.
- mem_ack_i  in  1  one-cycle completion pulse.
- mem_data_o  out  256  writeback line.
- mem_addr_o  out  32  line-aligned address.
- mem_enable_o  out  1  request valid.
- mem_write_o  out  1  1 = writeback, 0 = fetch.

Function
REQ-004 Organisation SHALL be direct-mapped: 16 sets, 32-byte lines, one valid bit and one dirty bit per set.
REQ-005 Address split SHALL be offset [4:0], word select [4:2], index [8:5], tag [31:9] (23 bits).
REQ-006 Hit SHALL mean valid[index] AND stored tag == cpu tag.
REQ-007 The FSM SHALL have states IDLE, WRITEBACK, ALLOCATE and REFILL.
REQ-008 A request is active when cpu_MemRead_i OR cpu_MemWrite_i is 1; if both are 1, the request SHALL be treated as a store.
REQ-009 In IDLE with no request: cpu_stall_o = 0, no state change, and mem_ack_i ignored.
REQ-010 On a load hit in IDLE, cpu_data_o SHALL present the selected word combinationally in the same cycle, with cpu_stall_o = 0.
REQ-011 On a store hit in IDLE:
- the addressed word SHALL be written at the next posedge;
- dirty SHALL be set;
- cpu_stall_o SHALL be 0.
REQ-012 On a miss in IDLE, cpu_stall_o SHALL be 1 combinationally in the same cycle.
- Next state SHALL be WRITEBACK if the victim is valid and dirty, else ALLOCATE.
REQ-013 In WRITEBACK:
- mem_enable_o = 1, mem_write_o = 1;
- mem_addr_o = {victim tag, index, 5'b0};
- mem_data_o = victim line.
- All SHALL be held until mem_ack_i = 1, then go to ALLOCATE.
REQ-014 In ALLOCATE:
- mem_enable_o = 1, mem_write_o = 0;
- mem_addr_o = {cpu tag, index, 5'b0}.
- On mem_ack_i, write mem_data_i, cpu tag, valid = 1 and dirty = 0 into the set, then go to REFILL.
REQ-015 REFILL SHALL last exactly one cycle and then return to IDLE, where the request re-evaluates as a hit.
REQ-016 cpu_stall_o SHALL be 1 in every non-IDLE state.
REQ-017 Minimum miss latency SHALL be: clean miss = ack cycle + 2; dirty miss = two acks + 2.
REQ-018 cpu_addr_i and the request signals SHALL be held stable by the pipeline while cpu_stall_o = 1; the block SHALL NOT latch them.
REQ-019 Outside WRITEBACK and ALLOCATE: mem_enable_o = 0 and mem_write_o = 0; mem_addr_o and mem_data_o are don't-care.

Reset
REQ-020 While rst_i = 1:
- state SHALL be IDLE;
- all 16 valid and dirty bits SHALL be 0;
- mem_enable_o = 0, mem_write_o = 0.
REQ-021 Reset asserted mid-miss SHALL abandon the transaction immediately, with no line update.
REQ-022 Tag and data arrays need not be reset.
REQ-023 After reset, the first access to any set SHALL miss.

Structure
REQ-024 Package dcache_pkg SHALL hold:
- the state encoding;
- SETS = 16, LINE_BITS = 256, TAG_BITS = 23, INDEX_BITS = 4, OFFSET_BITS = 5.
REQ-025 Tag/valid/dirty and data storage SHALL be one sub-module dcache_sram, which owns the arrays and the asynchronous clear of valid and dirty.
- It SHALL provide a combinational read and a single-port synchronous write.
REQ-026 The FSM, hit logic and word merge SHALL reside in dcache_controller.

Verification
REQ-027 Cold load: after reset, load 0x0000_0204 (set 0); memory acks after 3 cycles with word1 = 0xDEAD_BEEF -> one ALLOCATE request at 0x0000_0200, no writeback, cpu_data_o = 0xDEAD_BEEF once cpu_stall_o drops.
REQ-028 Store hit: store 0x1234_5678 to 0x0000_0208, then load 0x0000_0208 -> no stall on either access, load returns 0x1234_5678, set 0 dirty.
REQ-029 Dirty eviction: after REQ-028, load 0x0000_0408 (same set, new tag) -> a WRITEBACK at 0x0000_0200 with word2 = 0x1234_5678, then an ALLOCATE at 0x0000_0400.
REQ-030 Request hold: hold mem_ack_i low for 10 cycles in ALLOCATE -> mem_enable_o, mem_addr_o and cpu_stall_o stay constant for all 10 cycles.
REQ-031 Reset mid-op: assert rst_i during WRITEBACK -> mem_enable_o = 0 immediately, and the next access to that set misses with no writeback.
REQ-032 Simultaneous and idle cases: MemRead and MemWrite both 1 on a hit -> store performed; both 0 with a stray mem_ack_i -> no state change and cpu_stall_o = 0.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared geometry, state encoding and metadata layout for the direct-mapped data cache.
package dcache_pkg;

    localparam int SETS        = 16;
    localparam int LINE_BITS   = 256;
    localparam int TAG_BITS    = 23;
    localparam int INDEX_BITS  = 4;
    localparam int OFFSET_BITS = 5;
    localparam int WORD_BITS   = 32;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2,
        ST_REFILL    = 2'd3
    } state_e;

    typedef struct packed {
        logic                valid;
        logic                dirty;
        logic [TAG_BITS-1:0] tag;
    } meta_t;

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty and line storage: combinational read, single-port synchronous write.
module dcache_sram
    import dcache_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [INDEX_BITS-1:0] idx_i,
    input  logic                  we_i,
    input  meta_t                 wr_meta_i,
    input  logic [LINE_BITS-1:0]  wr_line_i,
    output meta_t                 rd_meta_o,
    output logic [LINE_BITS-1:0]  rd_line_o
);

    logic [SETS-1:0]      valid_q;
    logic [SETS-1:0]      dirty_q;
    logic [TAG_BITS-1:0]  tag_q  [SETS];
    logic [LINE_BITS-1:0] line_q [SETS];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (we_i) begin
            valid_q[idx_i] <= wr_meta_i.valid;
            dirty_q[idx_i] <= wr_meta_i.dirty;
        end
    end

    // NOTE: tag and line arrays carry no reset; a cleared valid bit makes their contents irrelevant.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            tag_q[idx_i]  <= wr_meta_i.tag;
            line_q[idx_i] <= wr_line_i;
        end
    end

    assign rd_meta_o.valid = valid_q[idx_i];
    assign rd_meta_o.dirty = dirty_q[idx_i];
    assign rd_meta_o.tag   = tag_q[idx_i];
    assign rd_line_o       = line_q[idx_i];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back data cache: hit detection, word merge and the miss FSM.
module dcache_controller
    import dcache_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [31:0]          cpu_addr_i,
    input  logic [31:0]          cpu_data_i,
    input  logic                 cpu_MemRead_i,
    input  logic                 cpu_MemWrite_i,
    output logic [31:0]          cpu_data_o,
    output logic                 cpu_stall_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i,
    output logic [LINE_BITS-1:0] mem_data_o,
    output logic [31:0]          mem_addr_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o
);

    state_e                 state_q, state_d;
    logic                   mem_enable_q, mem_write_q;
    logic [TAG_BITS-1:0]    cpu_tag;
    logic [INDEX_BITS-1:0]  index;
    logic [2:0]             word_sel;
    logic                   req, hit, miss;
    meta_t                  rd_meta, wr_meta;
    logic [LINE_BITS-1:0]   rd_line, wr_line;
    logic                   we;
    logic                   unused_addr_bits;

    assign cpu_tag          = cpu_addr_i[31:9];
    assign index            = cpu_addr_i[8:5];
    assign word_sel         = cpu_addr_i[4:2];
    assign unused_addr_bits = ^cpu_addr_i[1:0];

    assign req  = cpu_MemRead_i | cpu_MemWrite_i;
    assign hit  = rd_meta.valid && (rd_meta.tag == cpu_tag);
    assign miss = req && !hit;

    dcache_sram u_sram (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .idx_i     (index),
        .we_i      (we),
        .wr_meta_i (wr_meta),
        .wr_line_i (wr_line),
        .rd_meta_o (rd_meta),
        .rd_line_o (rd_line)
    );

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
    always_comb begin
        state_d       = state_q;
        we            = 1'b0;
        wr_meta.valid = 1'b1;
        wr_meta.dirty = 1'b1;
        wr_meta.tag   = cpu_tag;
        wr_line       = rd_line;
        case (state_q)
            ST_IDLE: begin
                if (miss) begin
                    state_d = (rd_meta.valid && rd_meta.dirty) ? ST_WRITEBACK : ST_ALLOCATE;
                end else if (req && cpu_MemWrite_i) begin
                    // Store hit: merge the word into the current line and mark it dirty.
                    we = 1'b1;
                    wr_line[word_sel*WORD_BITS +: WORD_BITS] = cpu_data_i;
                end
            end
            ST_WRITEBACK: if (mem_ack_i) state_d = ST_ALLOCATE;
            ST_ALLOCATE: begin
                if (mem_ack_i) begin
                    we            = 1'b1;
                    wr_meta.dirty = 1'b0;
                    wr_line       = mem_data_i;
                    state_d       = ST_REFILL;
                end
            end
            ST_REFILL: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_enable_q <= (state_d == ST_WRITEBACK) || (state_d == ST_ALLOCATE);
            mem_write_q  <= (state_d == ST_WRITEBACK);
        end
    end

    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;
    assign mem_data_o   = rd_line;
    assign mem_addr_o   = (state_q == ST_WRITEBACK) ? {rd_meta.tag, index, 5'b0}
                                                    : {cpu_tag, index, 5'b0};
    assign cpu_stall_o  = (state_q != ST_IDLE) || miss;
    assign cpu_data_o   = rd_line[word_sel*WORD_BITS +: WORD_BITS];

endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench: a line-level cache model predicts memory traffic and load data; a monitor compares.
module tb_dcache_controller;

    typedef enum logic [1:0] {EV_WB, EV_FETCH, EV_LOAD, EV_STORE} ev_e;
    typedef struct {
        ev_e          kind;
        logic [31:0]  addr;
        logic [255:0] data;
    } ev_t;

    logic         clk, rst;
    logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata, mem_addr_o;
    logic         cpu_rd, cpu_wr, cpu_stall_o;
    logic [255:0] mem_data_i, mem_data_o;
    logic         mem_ack_i, mem_enable_o, mem_write_o;

    int n_checks = 0;
    int n_errors = 0;

    ev_t          exp_q[$];
    logic [255:0] ref_mem  [logic [31:0]];
    logic [255:0] phys_mem [logic [31:0]];
    bit           r_valid [16];
    bit           r_dirty [16];
    logic [22:0]  r_tag   [16];
    logic [255:0] r_line  [16];
    int           fixed_delay = -1;

    dcache_controller dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .cpu_addr_i     (cpu_addr),
        .cpu_data_i     (cpu_wdata),
        .cpu_MemRead_i  (cpu_rd),
        .cpu_MemWrite_i (cpu_wr),
        .cpu_data_o     (cpu_rdata),
        .cpu_stall_o    (cpu_stall_o),
        .mem_data_i     (mem_data_i),
        .mem_ack_i      (mem_ack_i),
        .mem_data_o     (mem_data_o),
        .mem_addr_o     (mem_addr_o),
        .mem_enable_o   (mem_enable_o),
        .mem_write_o    (mem_write_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input bit ok, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic finish_sim();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    endtask

    function automatic logic [255:0] line_init(input logic [31:0] la);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = (la + 32'(i * 4)) ^ 32'h5A5A_0000;
        return l;
    endfunction

    function automatic logic [255:0] read_line(input bit phys, input logic [31:0] la);
        if (phys) return phys_mem.exists(la) ? phys_mem[la] : line_init(la);
        return ref_mem.exists(la) ? ref_mem[la] : line_init(la);
    endfunction

    // Reference model: one access against the line-level cache, queuing the traffic it implies.
    task automatic predict(input logic [31:0] addr, input bit st, input logic [31:0] wdata,
                           output bit hit, output bit dirty_miss);
        int          idx = int'(addr[8:5]);
        int          w   = int'(addr[4:2]);
        logic [22:0] tg  = addr[31:9];
        logic [31:0] la;
        hit        = r_valid[idx] && (r_tag[idx] == tg);
        dirty_miss = !hit && r_valid[idx] && r_dirty[idx];
        if (dirty_miss) begin
            la = {r_tag[idx], addr[8:5], 5'b0};
            ref_mem[la] = r_line[idx];
            exp_q.push_back(ev_t'{EV_WB, la, r_line[idx]});
        end
        if (!hit) begin
            la = {tg, addr[8:5], 5'b0};
            exp_q.push_back(ev_t'{EV_FETCH, la, '0});
            r_line[idx]  = read_line(1'b0, la);
            r_valid[idx] = 1'b1;
            r_dirty[idx] = 1'b0;
            r_tag[idx]   = tg;
        end
        if (st) begin
            r_line[idx][w*32 +: 32] = wdata;
            r_dirty[idx] = 1'b1;
            exp_q.push_back(ev_t'{EV_STORE, addr, '0});
        end else begin
            exp_q.push_back(ev_t'{EV_LOAD, addr, {224'b0, r_line[idx][w*32 +: 32]}});
        end
    endtask

    task automatic observe(input ev_e kind, input logic [31:0] addr, input logic [255:0] data);
        ev_t e;
        check("sb_event_expected", exp_q.size() != 0, 256'(kind), 256'(exp_q.size()));
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        check("ev_kind", kind == e.kind, 256'(kind), 256'(e.kind));
        if (kind != e.kind) return;
        case (kind)
            EV_WB: begin
                check("wb_addr", addr == e.addr, 256'(addr), 256'(e.addr));
                check("wb_line", data == e.data, data, e.data);
            end
            EV_FETCH: check("fetch_addr", addr == e.addr, 256'(addr), 256'(e.addr));
            EV_LOAD:  check("load_data", data[31:0] == e.data[31:0], data, e.data);
            default:  ;
        endcase
    endtask

    // Monitor: memory handshakes and CPU acceptances, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mem_enable_o && mem_ack_i)
                    observe(mem_write_o ? EV_WB : EV_FETCH, mem_addr_o, mem_data_o);
                if ((cpu_rd || cpu_wr) && !cpu_stall_o)
                    observe(cpu_wr ? EV_STORE : EV_LOAD, cpu_addr, {224'b0, cpu_rdata});
            end
        end
    end

    // Memory responder: acks each request after a programmable or random delay.
    initial begin
        bit busy = 0;
        bit acking = 0;
        int cnt = 0;
        int target = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                mem_ack_i = 1'b0;
                busy = 0;
                acking = 0;
            end else if (acking) begin
                mem_ack_i = 1'b0;
                acking = 0;
            end else if (mem_enable_o) begin
                if (!busy) begin
                    busy   = 1;
                    cnt    = 0;
                    target = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 4));
                end
                if (cnt >= target) begin
                    mem_data_i = read_line(1'b1, mem_addr_o);
                    if (mem_write_o) phys_mem[mem_addr_o] = mem_data_o;
                    mem_ack_i = 1'b1;
                    acking = 1;
                    busy = 0;
                end else begin
                    cnt++;
                end
            end
        end
    end

    // Driver: present one request, hold it until the stall drops, then release it after the edge.
    task automatic issue(input logic [31:0] addr, input bit rd, input bit wr,
                         input logic [31:0] wdata, input bit hold);
        bit hit, dirty_miss;
        int stall_cyc = 0;
        int hold_n = 0;
        predict(addr, wr, wdata, hit, dirty_miss);
        cpu_addr = addr; cpu_wdata = wdata; cpu_rd = rd; cpu_wr = wr;
        forever begin
            @(negedge clk);
            if (!cpu_stall_o) break;
            if (hold && mem_enable_o && !mem_write_o && hold_n < 10) begin
                check("hold_addr", mem_addr_o == {addr[31:5], 5'b0}, 256'(mem_addr_o), 256'({addr[31:5], 5'b0}));
                check("hold_stall", cpu_stall_o == 1'b1, 256'(cpu_stall_o), 256'(1));
                hold_n++;
            end
            stall_cyc++;
            if (stall_cyc > 200) begin
                check("accept_timeout", 1'b0, 256'(stall_cyc), 256'(200));
                finish_sim();
            end
        end
        if (hit)             check("hit_no_stall", stall_cyc == 0, 256'(stall_cyc), 256'(0));
        else if (dirty_miss) check("dirty_miss_latency", stall_cyc >= 4, 256'(stall_cyc), 256'(4));
        else                 check("clean_miss_latency", stall_cyc >= 3, 256'(stall_cyc), 256'(3));
        if (hold) check("hold_cycles", hold_n == 10, 256'(hold_n), 256'(10));
        @(posedge clk);
        #1;
        cpu_rd = 1'b0; cpu_wr = 1'b0;
    endtask

    initial begin
        logic [255:0] l;
        bit           found;
        rst = 1'b1; cpu_addr = '0; cpu_wdata = '0; cpu_rd = 1'b0; cpu_wr = 1'b0;
        mem_data_i = '0; mem_ack_i = 1'b0;
        for (int i = 0; i < 16; i++) begin r_valid[i] = 0; r_dirty[i] = 0; end
        l = line_init(32'h0000_0200);
        l[63:32] = 32'hDEAD_BEEF;
        ref_mem[32'h0000_0200]  = l;
        phys_mem[32'h0000_0200] = l;

        repeat (2) @(negedge clk);
        check("rst_enable", mem_enable_o == 1'b0, 256'(mem_enable_o), 256'(0));
        check("rst_write", mem_write_o == 1'b0, 256'(mem_write_o), 256'(0));
        check("rst_stall", cpu_stall_o == 1'b0, 256'(cpu_stall_o), 256'(0));
        @(posedge clk);
        #1 rst = 1'b0;

        // Cold load, store hit, load hit, dirty eviction.
        fixed_delay = 3;
        issue(32'h0000_0204, 1, 0, '0, 0);
        fixed_delay = -1;
        issue(32'h0000_0208, 0, 1, 32'h1234_5678, 0);
        issue(32'h0000_0208, 1, 0, '0, 0);
        issue(32'h0000_0408, 1, 0, '0, 0);

        // Both request lines on a hit behave as a store.
        issue(32'h0000_040C, 1, 1, 32'hCAFE_F00D, 0);
        issue(32'h0000_040C, 1, 0, '0, 0);

        // Stray ack with no request: no stall, no memory request, line untouched.
        mem_data_i = '1;
        mem_ack_i = 1'b1;
        @(negedge clk);
        check("stray_stall", cpu_stall_o == 1'b0, 256'(cpu_stall_o), 256'(0));
        check("stray_enable", mem_enable_o == 1'b0, 256'(mem_enable_o), 256'(0));
        @(posedge clk);
        #1 mem_ack_i = 1'b0;
        @(negedge clk);
        check("stray_idle_after", cpu_stall_o == 1'b0, 256'(cpu_stall_o), 256'(0));
        @(posedge clk);
        #1;
        issue(32'h0000_040C, 1, 0, '0, 0);

        // ALLOCATE request held steady across a slow ack.
        fixed_delay = 12;
        issue(32'h0000_08E4, 1, 0, '0, 1);
        fixed_delay = -1;

        // Reset in the middle of a writeback abandons it.
        issue(32'h0000_0A28, 0, 1, 32'hAAAA_5555, 0);
        fixed_delay = 30;
        cpu_addr = 32'h0000_0C28; cpu_rd = 1'b1;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_enable_o && mem_write_o) begin found = 1; break; end
        end
        check("wb_reached", found, 256'(found), 256'(1));
        rst = 1'b1;
        #1;
        check("midop_rst_enable", mem_enable_o == 1'b0, 256'(mem_enable_o), 256'(0));
        check("midop_rst_write", mem_write_o == 1'b0, 256'(mem_write_o), 256'(0));
        cpu_rd = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 16; i++) begin r_valid[i] = 0; r_dirty[i] = 0; end
        fixed_delay = -1;
        issue(32'h0000_0C28, 1, 0, '0, 0);
        issue(32'h0000_0A28, 1, 0, '0, 0);

        // Randomised traffic over a few tags per set to exercise hits, clean and dirty misses.
        for (int n = 0; n < 300; n++) begin
            logic [22:0] tg  = 23'($urandom_range(0, 3));
            logic [3:0]  idx = 4'($urandom_range(0, 15));
            logic [2:0]  w   = 3'($urandom_range(0, 7));
            int          op  = int'($urandom_range(0, 2));
            issue({tg, idx, w, 2'b00}, op != 1, op != 0, $urandom, 0);
        end

        repeat (3) @(negedge clk);
        check("sb_drained", exp_q.size() == 0, 256'(exp_q.size()), 256'(0));
        finish_sim();
    end

endmodule
